// File: rtl/uac2_pkg.sv
// rtl/uac2_pkg.sv - shared playback scheduler types and widths
package uac2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREFILL,
      WAIT_FRM,
      ISSUE,
      WAIT_DAT,
      PRESENT
   } state_t;

   localparam int SAMPLE_W   = 32;
   localparam int BUF_WORD_W = 16;

endpackage

// File: rtl/audio_rd_sched.sv
// rtl/audio_rd_sched.sv - per-frame stereo fetch from the sample buffer; optional UNDERRUN_CNT_EN
// Owns prefill, underrun muting/recovery and late-frame detection.
module audio_rd_sched
   import uac2_pkg::*;
#(
   parameter int WORDS_PER_CH = 2,
   parameter int RD_LAT       = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_enable,
   input  logic                  i_frame_strobe,
   output logic                  o_buf_rd_req,
   input  logic [BUF_WORD_W-1:0] i_buf_rd_data,
   input  logic                  i_buf_ef_n,
   input  logic                  i_buf_half_n,
   output logic [SAMPLE_W-1:0]   o_left_sample,
   output logic [SAMPLE_W-1:0]   o_right_sample,
   output logic                  o_sample_valid,
   output logic                  o_underrun,
   output logic                  o_late_frame
`ifdef UNDERRUN_CNT_EN
   ,
   output logic [15:0]           o_underrun_cnt
`endif
);

   localparam int N_WORDS = 2 * WORDS_PER_CH;
   localparam int CH_W    = WORDS_PER_CH * BUF_WORD_W;
   localparam int CAP_W   = N_WORDS * BUF_WORD_W;
   localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam int LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

   state_t                      r_state;
   logic [IDX_W-1:0]            r_idx;
   logic [LAT_W-1:0]            r_lat;
   logic [CAP_W-BUF_WORD_W-1:0] r_cap;
   logic                        r_abort;

   logic [CAP_W-1:0]            w_full;
   logic [SAMPLE_W-1:0]         w_left;
   logic [SAMPLE_W-1:0]         w_right;

   // Words arrive most-significant first, so a left shift leaves L_hi at the top.
   assign w_full  = {r_cap, i_buf_rd_data};
   assign w_left  = SAMPLE_W'(w_full[CAP_W-1 -: CH_W]) << (SAMPLE_W - CH_W);
   assign w_right = SAMPLE_W'(w_full[CH_W-1:0]) << (SAMPLE_W - CH_W);

   // The request lives only in ISSUE, so consecutive requests always see a low cycle.
   assign o_buf_rd_req = (r_state == ISSUE) && i_buf_ef_n;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= IDLE;
         r_idx          <= '0;
         r_lat          <= '0;
         r_cap          <= '0;
         r_abort        <= 1'b0;
         o_left_sample  <= '0;
         o_right_sample <= '0;
         o_sample_valid <= 1'b0;
         o_underrun     <= 1'b0;
         o_late_frame   <= 1'b0;
      end else begin
         o_sample_valid <= 1'b0;
         o_underrun     <= 1'b0;
         o_late_frame   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_enable) r_state <= PREFILL;
            end
            PREFILL: begin
               if (!i_enable) begin
                  r_state        <= IDLE;
                  o_left_sample  <= '0;
                  o_right_sample <= '0;
               end else if (!i_buf_half_n) begin
                  r_state <= WAIT_FRM;
               end
            end
            WAIT_FRM: begin
               if (!i_enable) begin
                  r_state        <= IDLE;
                  o_left_sample  <= '0;
                  o_right_sample <= '0;
               end else if (i_frame_strobe) begin
                  r_state <= ISSUE;
                  r_idx   <= '0;
                  r_abort <= 1'b0;
               end
            end
            ISSUE: begin
               if (!i_buf_ef_n) begin
                  o_underrun     <= 1'b1;
                  o_sample_valid <= 1'b1;
                  o_left_sample  <= '0;
                  o_right_sample <= '0;
                  r_state        <= PREFILL;
               end else begin
                  r_lat   <= LAT_INIT;
                  r_state <= WAIT_DAT;
                  if (!i_enable) r_abort <= 1'b1;
                  if (i_frame_strobe) o_late_frame <= 1'b1;
               end
            end
            WAIT_DAT: begin
               if (i_frame_strobe) o_late_frame <= 1'b1;
               if (!i_enable) r_abort <= 1'b1;
               if (r_lat == '0) begin
                  r_cap <= w_full[CAP_W-BUF_WORD_W-1:0];
                  if (r_abort || !i_enable) begin
                     r_state        <= IDLE;
                     r_abort        <= 1'b0;
                     o_left_sample  <= '0;
                     o_right_sample <= '0;
                  end else if (r_idx == LAST_IDX) begin
                     o_left_sample  <= w_left;
                     o_right_sample <= w_right;
                     o_sample_valid <= 1'b1;
                     r_state        <= PRESENT;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= ISSUE;
                  end
               end else begin
                  r_lat <= r_lat - 1'b1;
               end
            end
            PRESENT: begin
               if (i_frame_strobe) o_late_frame <= 1'b1;
               r_state <= WAIT_FRM;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef UNDERRUN_CNT_EN
   logic [15:0] r_underrun_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_underrun_cnt <= '0;
      end else if ((r_state == ISSUE) && !i_buf_ef_n && (r_underrun_cnt != 16'hFFFF)) begin
         r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
   end

   assign o_underrun_cnt = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_audio_rd_sched.sv
// tb/tb_audio_rd_sched.sv - directed bench with frame-schedule model for audio_rd_sched
module tb_audio_rd_sched;

   localparam int MAXC = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        strobe;
   logic        req;
   logic [15:0] rd_data = 16'hDEAD;
   logic        ef_n;
   logic        half_n;
   logic [31:0] left;
   logic [31:0] right;
   logic        valid;
   logic        und;
   logic        late;
`ifdef UNDERRUN_CNT_EN
   logic [15:0] ucnt;
`endif

   always #5 clk = ~clk;

   audio_rd_sched #(.WORDS_PER_CH(2), .RD_LAT(2)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_enable       (enable),
      .i_frame_strobe (strobe),
      .o_buf_rd_req   (req),
      .i_buf_rd_data  (rd_data),
      .i_buf_ef_n     (ef_n),
      .i_buf_half_n   (half_n),
      .o_left_sample  (left),
      .o_right_sample (right),
      .o_sample_valid (valid),
      .o_underrun     (und),
      .o_late_frame   (late)
`ifdef UNDERRUN_CNT_EN
      ,
      .o_underrun_cnt (ucnt)
`endif
   );

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc <= cyc + 1;
   end

   // Buffer: words pushed by the stimulus, popped on each request rising edge, data RD_LAT=2 later.
   logic [15:0] src [0:255];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic        prev_req = 1'b0;
   logic        stg_v = 1'b0;
   logic [15:0] stg = 16'h0;

   assign ef_n   = (wr_ptr != rd_ptr);
   assign half_n = !((wr_ptr - rd_ptr) >= 4);

   initial forever begin
      @(posedge clk);
      prev_req <= req;
      stg_v    <= 1'b0;
      if (req && !prev_req && (rd_ptr != wr_ptr)) begin
         stg    <= src[rd_ptr % 256];
         stg_v  <= 1'b1;
         rd_ptr <= rd_ptr + 1;
      end
      rd_data <= stg_v ? stg : 16'hDEAD;
   end

   // Literal expectations posted by the stimulus, drained by the compare process.
   string       lit_name [0:63];
   logic [31:0] lit_act  [0:63];
   logic [31:0] lit_exp  [0:63];
   int          lit_wr = 0;
   int          lit_rd = 0;

   task automatic post(input string nm, input logic [31:0] a, input logic [31:0] e);
      lit_name[lit_wr] = nm;
      lit_act[lit_wr]  = a;
      lit_exp[lit_wr]  = e;
      lit_wr++;
   endtask

   int n_cmp = 0;
   int n_fail = 0;

   task automatic do_chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   // Schedule model: a frame accepted at cycle c yields requests at c+1+3k and the
   // result 13 clks later; an empty buffer at word n ends it at c+2+3n with zeros.
   bit          exp_req  [MAXC];
   bit          exp_val  [MAXC];
   bit          exp_und  [MAXC];
   bit          exp_late [MAXC];
   bit          chg_en   [MAXC];
   logic [31:0] chg_l    [MAXC];
   logic [31:0] chg_r    [MAXC];

   task automatic set_samples(input int c, input logic [31:0] l, input logic [31:0] r);
      chg_en[c] = 1'b1;
      chg_l[c]  = l;
      chg_r[c]  = r;
   endtask

   initial begin
      logic [31:0] cur_l;
      logic [31:0] cur_r;
      int  mode;
      int  b_start, b_end, b_next, b_nw;
      bit  b_und;
      bit  armed;
      int  c, f, n, k, ne, rp;
      cur_l = '0; cur_r = '0; mode = 0; armed = 1'b0;
      b_start = 0; b_end = 0; b_next = 0; b_nw = 0; b_und = 1'b0;
      forever begin
         @(negedge clk);
         c = cyc;
         while (lit_rd < lit_wr) begin
            do_chk(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
         end
         if (c + 45 >= MAXC) continue;
         if (chg_en[c]) begin
            cur_l = chg_l[c];
            cur_r = chg_r[c];
         end
         if (armed) begin
            do_chk("buf_rd_req",   {31'd0, req},   {31'd0, exp_req[c]});
            do_chk("sample_valid", {31'd0, valid}, {31'd0, exp_val[c]});
            do_chk("underrun",     {31'd0, und},   {31'd0, exp_und[c]});
            do_chk("late_frame",   {31'd0, late},  {31'd0, exp_late[c]});
            do_chk("left_sample",  left,  cur_l);
            do_chk("right_sample", right, cur_r);
         end
         if (rst) begin
            for (int i = c + 1; i < c + 40; i++) begin
               exp_req[i] = 0; exp_val[i] = 0; exp_und[i] = 0; exp_late[i] = 0; chg_en[i] = 0;
            end
            set_samples(c + 1, '0, '0);
            mode  = 0;
            armed = 1'b1;
         end else begin
            case (mode)
               0: if (enable) mode = 1;
               1: begin
                  if (!enable) begin
                     mode = 0;
                     set_samples(c + 1, '0, '0);
                  end else if ((wr_ptr - rd_ptr) >= 4) begin
                     mode = 2;
                  end
               end
               2: begin
                  if (!enable) begin
                     mode = 0;
                     set_samples(c + 1, '0, '0);
                  end else if (strobe) begin
                     f  = wr_ptr - rd_ptr;
                     n  = (f < 4) ? f : 4;
                     rp = rd_ptr;
                     for (int j = 0; j < n; j++) exp_req[c + 1 + 3 * j] = 1'b1;
                     b_start = c;
                     b_nw    = n;
                     mode    = 3;
                     if (n == 4) begin
                        exp_val[c + 13] = 1'b1;
                        set_samples(c + 13, {src[rp % 256], src[(rp + 1) % 256]},
                                            {src[(rp + 2) % 256], src[(rp + 3) % 256]});
                        b_end  = c + 13;
                        b_next = 2;
                        b_und  = 1'b0;
                     end else begin
                        exp_val[c + 2 + 3 * n] = 1'b1;
                        exp_und[c + 2 + 3 * n] = 1'b1;
                        set_samples(c + 2 + 3 * n, '0, '0);
                        b_end  = c + 1 + 3 * n;
                        b_next = 1;
                        b_und  = 1'b1;
                     end
                  end
               end
               default: begin
                  if (strobe && !(b_und && c == b_end)) exp_late[c + 1] = 1'b1;
                  if (!enable && b_next != 0 && c < b_start + 1 + 3 * b_nw) begin
                     k  = (c - b_start - 1) / 3;
                     ne = b_start + 3 + 3 * k;
                     for (int i = c + 1; i <= b_end + 1; i++) begin
                        exp_req[i] = 0; exp_val[i] = 0; exp_und[i] = 0; chg_en[i] = 0;
                     end
                     set_samples(ne + 1, '0, '0);
                     b_end  = ne;
                     b_next = 0;
                     b_und  = 1'b0;
                  end
                  if (c == b_end) mode = b_next;
               end
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] w);
      src[wr_ptr % 256] = w;
      wr_ptr++;
   endtask

   task automatic strobe_once();
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, rq, vc, lc, lat, first_req, second_req;
      bit found;
      logic [31:0] l_cap, r_cap;

      rst = 1'b1; enable = 1'b0; strobe = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      post("reset_req", {31'd0, req}, 32'd0);
      post("reset_left", left, 32'd0);
      post("reset_valid", {31'd0, valid}, 32'd0);

      // 1: prefill holds until half full
      enable = 1'b1;
      rq = 0;
      repeat (20) begin tick(); rq += req; end
      post("prefill_no_req", rq, 0);
      push(16'h1234); push(16'h5678); push(16'h9ABC); push(16'hDEF0);
      repeat (3) tick();
      post("prefill_left", left, 32'd0);

      // 2: normal frame
      s = cyc; strobe_once();
      rq = 0; found = 0; lat = 0; first_req = -1; second_req = -1;
      for (int i = 0; i < 40; i++) begin
         if (req) begin
            if (first_req < 0) first_req = cyc;
            else if (second_req < 0) second_req = cyc;
            rq++;
         end
         if (valid) begin found = 1; lat = cyc - s; l_cap = left; r_cap = right; break; end
         tick();
      end
      post("frame_valid_seen", {31'd0, found}, 32'd1);
      post("frame_latency", lat, 13);
      post("frame_req_count", rq, 4);
      post("frame_req_spacing", second_req - first_req, 3);
      post("frame_left", l_cap, 32'h12345678);
      post("frame_right", r_cap, 32'h9ABCDEF0);
      repeat (2) tick();

      // 3: underrun at word 2
      push(16'h1111); push(16'h2222);
      s = cyc; strobe_once();
      found = 0;
      for (int i = 0; i < 40; i++) begin
         if (und) begin
            found = 1; lat = cyc - s; l_cap = left;
            post("underrun_valid", {31'd0, valid}, 32'd1);
            break;
         end
         tick();
      end
      post("underrun_seen", {31'd0, found}, 32'd1);
      post("underrun_latency", lat, 8);
      post("underrun_left", l_cap, 32'd0);
      rq = 0; lc = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 7) strobe = 1'b1;
         tick();
         strobe = 1'b0;
         rq += req; lc += late;
      end
      post("prefill_after_underrun_req", rq, 0);
      post("prefill_strobe_no_late", lc, 0);
      push(16'hCAFE); push(16'hBABE); push(16'h0123); push(16'h4567);
      repeat (3) tick();

      // 4: late strobe 5 clks into the fetch
      s = cyc; strobe_once();
      repeat (4) tick();
      strobe = 1'b1;
      vc = 0; lc = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         strobe = 1'b0;
         lc += late;
         if (valid) begin vc++; l_cap = left; r_cap = right; end
      end
      post("late_count", lc, 1);
      post("late_valid_count", vc, 1);
      post("late_left", l_cap, 32'hCAFEBABE);
      post("late_right", r_cap, 32'h01234567);

      // 5: enable dropped in WAIT_DAT of word 1, then reset mid-fetch
      push(16'hAAAA); push(16'hBBBB); push(16'hCCCC); push(16'hDDDD);
      repeat (3) tick();
      s = cyc; strobe_once();
      rq = 0; vc = 0;
      for (int i = 0; i < 25; i++) begin
         if (cyc == s + 5) enable = 1'b0;
         rq += req; vc += valid;
         tick();
      end
      post("abort_req_count", rq, 2);
      post("abort_no_valid", vc, 0);
      post("abort_left", left, 32'd0);
      enable = 1'b1;
      push(16'hEEEE); push(16'hFFFF);
      repeat (4) tick();
      s = cyc; strobe_once();
      repeat (3) tick();
      post("rst_mid_req_before", {31'd0, req}, 32'd1);
      rst = 1'b1;
      tick();
      post("rst_mid_req_after", {31'd0, req}, 32'd0);
      rst = 1'b0;
      tick();

`ifdef UNDERRUN_CNT_EN
      // 6: underrun counter and saturation
      post("ucnt_after_rst", {16'd0, ucnt}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         push(16'h0101); push(16'h0202); push(16'h0303); push(16'h0404);
         repeat (4) tick();
         strobe_once();
         repeat (20) tick();
         strobe_once();
         repeat (20) tick();
      end
      post("ucnt_three", {16'd0, ucnt}, 32'd3);
      force dut.r_underrun_cnt = 16'hFFFF;
      tick();
      release dut.r_underrun_cnt;
      push(16'h0505); push(16'h0606); push(16'h0707); push(16'h0808);
      repeat (4) tick();
      strobe_once();
      repeat (20) tick();
      strobe_once();
      repeat (20) tick();
      post("ucnt_saturated", {16'd0, ucnt}, 32'h0000FFFF);
`endif

      repeat (5) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
